// File: rtl/bit_serializer_pkg.sv
// Shared sequencing definitions for the serializer and the 1011 detector bench.
// State encodings are plain localparams so the detector side can reuse them
// without depending on the enum type.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
  localparam logic [1:0] ST_PARITY_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE_ENC,
    SHIFT  = ST_SHIFT_ENC,
    PARITY = ST_PARITY_ENC
  } state_e;

endpackage

// File: rtl/bit_serializer_down_counter.sv
// Loadable down-counter with zero flag; parks at zero instead of wrapping.
module down_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          zero_o
);

  logic [CW-1:0] count_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the 1011 sequence detector.
// Optional even-parity bit after each word: define SERIALIZER_PARITY_EN.
//
// state  | meaning
// IDLE   | no word in flight, ready for a new word, serial_out at IDLE_LEVEL
// SHIFT  | one data bit per cycle; counter==0 marks the last data bit
// PARITY | even-parity bit of the captured word (SERIALIZER_PARITY_EN only)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_q, serial_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Bit that leaves first, and the word left behind once it has gone.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  down_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  // Ready in IDLE and during the final cycle of a word (back-to-back window).
  always_comb begin
    load_ready = 1'b0;
    case (state_q)
      IDLE:   load_ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      SHIFT:  load_ready = 1'b0;
      PARITY: load_ready = 1'b1;
`else
      SHIFT:  load_ready = cnt_zero;
`endif
      default: load_ready = 1'b0;
    endcase
  end

  assign accept = load_valid && load_ready;

  // Next state and next registered outputs; an accepted word overrides all.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    serial_d = IDLE_LEVEL;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (!cnt_zero) begin
          serial_d = head_bit(shreg_q);
          shreg_d  = drop_head(shreg_q);
          valid_d  = 1'b1;
          cnt_dec  = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          done_d   = (cnt == CW'(1));
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d  = PARITY;
          serial_d = parity_q;
          valid_d  = 1'b1;
          done_d   = 1'b1;
`else
          state_d  = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = SHIFT;
      serial_d = head_bit(data_in);
      shreg_d  = drop_head(data_in);
      valid_d  = 1'b1;
      done_d   = 1'b0;
      cnt_load = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

  // State, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      serial_q <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out   = serial_q;
  assign serial_valid = valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two WIDTH=4 instances (A: MSB first, idle 0;
// B: LSB first, idle 1). Expected bit streams come from a vector table and
// directed sequences, queued per instance when the word is offered and
// compared every cycle against serial_valid/serial_out/done.
module tb_bit_serializer;

  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int PERIOD = PAR ? W + 1 : W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] data_a, data_b;
  logic valid_a, valid_b;
  logic ready_a, ready_b, so_a, so_b, sv_a, sv_b, done_a, done_b;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(data_a), .load_valid(valid_a),
    .load_ready(ready_a), .serial_out(so_a), .serial_valid(sv_a), .done(done_a)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst(rst), .data_in(data_b), .load_valid(valid_b),
    .load_ready(ready_b), .serial_out(so_b), .serial_valid(sv_b), .done(done_b)
  );

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  typedef struct {
    int           dut;
    logic [W-1:0] data;
    logic [W-1:0] seq;   // expected wire order, leftmost bit first
    logic         par;
    int           gap;   // idle cycles with load_valid low afterwards; 0 = back-to-back
  } vec_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  vec_t vecs[10];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int dut, input logic [W-1:0] seq, input logic par);
    exp_t e;
    logic [W-1:0] s;
    s = seq;
    for (int i = 0; i < W; i++) begin
      e.b = s[W-1];
      e.d = (i == W - 1) && !PAR;
      s = s << 1;
      if (dut == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (PAR) begin
      e.b = par;
      e.d = 1'b1;
      if (dut == 0) qa.push_back(e); else qb.push_back(e);
    end
  endfunction

  // Offer a word from a negedge; queue its expected bits when ready is seen.
  task automatic send(input int dut, input logic [W-1:0] d, input logic [W-1:0] seq,
                      input logic par);
    bit got;
    got = 1'b0;
    if (dut == 0) begin data_a = d; valid_a = 1'b1; end
    else begin data_b = d; valid_b = 1'b1; end
    for (int n = 0; n < 50 && !got; n++) begin
      if ((dut == 0) ? ready_a : ready_b) begin
        push_exp(dut, seq, par);
        got = 1'b1;
      end
      @(negedge clk);
    end
    check("accept_timeout", got, 1'b1);
  endtask

  // Scoreboard: serial_valid must track queued bits exactly, with no gaps.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("valid_a", sv_a, qa.size() > 0);
      if (sv_a && qa.size() > 0) begin
        ea = qa.pop_front();
        check("bit_a", so_a, ea.b);
        check("done_a", done_a, ea.d);
      end else if (!sv_a) begin
        check("idle_a", so_a, 1'b0);
        check("nodone_a", done_a, 1'b0);
      end
      check("valid_b", sv_b, qb.size() > 0);
      if (sv_b && qb.size() > 0) begin
        eb = qb.pop_front();
        check("bit_b", so_b, eb.b);
        check("done_b", done_b, eb.d);
      end else if (!sv_b) begin
        check("idle_b", so_b, 1'b1);
        check("nodone_b", done_b, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 4'b1011, 4'b1011, 1'b1, 6};
    vecs[1] = '{0, 4'b1011, 4'b1011, 1'b1, 0};
    vecs[2] = '{0, 4'b0110, 4'b0110, 1'b0, 6};
    vecs[3] = '{1, 4'b1101, 4'b1011, 1'b1, 6};
    vecs[4] = '{1, 4'b0011, 4'b1100, 1'b0, 0};
    vecs[5] = '{1, 4'b1000, 4'b0001, 1'b1, 6};
    vecs[6] = '{0, 4'b0000, 4'b0000, 1'b0, 0};
    vecs[7] = '{0, 4'b1111, 4'b1111, 1'b0, 6};
    vecs[8] = '{0, 4'b1001, 4'b1001, 1'b0, 6};
    vecs[9] = '{1, 4'b0110, 4'b0110, 1'b0, 6};

    data_a = '0; data_b = '0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_a", ready_a, 1'b1);
    check("rst_valid_a", sv_a, 1'b0);
    check("rst_out_a", so_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_out_b", so_b, 1'b1);
    check("rst_ready_b", ready_b, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].dut, vecs[i].data, vecs[i].seq, vecs[i].par);
      if (vecs[i].gap > 0) begin
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (vecs[i].gap) @(negedge clk);
      end
    end

    // Busy ignore: 1111 offered while shifting, withdrawn right at the window.
    send(0, 4'b1011, 4'b1011, 1'b1);
    data_a = 4'b1111;
    valid_a = 1'b1;
    for (int k = 1; k <= PERIOD; k++) begin
      check("ready_window_a", ready_a, k == PERIOD);
      if (k == PERIOD) valid_a = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Busy then held through the window: accepted with zero gap.
    send(0, 4'b1011, 4'b1011, 1'b1);
    send(0, 4'b1111, 4'b1111, 1'b0);
    valid_a = 1'b0;
    repeat (PERIOD + 3) @(negedge clk);

    // Reset during bit 2: outputs idle at once, partial word dropped.
    send(0, 4'b1001, 4'b1001, 1'b0);
    valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_out_a", so_a, 1'b0);
    check("rstmid_valid_a", sv_a, 1'b0);
    check("rstmid_done_a", done_a, 1'b0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstrel_ready_a", ready_a, 1'b1);
    check("rstrel_ready_b", ready_b, 1'b1);
    @(negedge clk);
    send(0, 4'b0110, 4'b0110, 1'b0);
    send(1, 4'b1101, 4'b1011, 1'b1);
    valid_a = 1'b0;
    valid_b = 1'b0;

    repeat (PERIOD + 6) @(negedge clk);
    check("drain_a", qa.size() == 0, 1'b1);
    check("drain_b", qb.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
